instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction memory. Owns the PC and drives the

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// registers the returned word into IF/ID. Handles stall, flush, redirect and halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        halt_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // 33 bits so a 32-bit PC compared against the limit can never alias.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] redir_raw, redir_tgt;
  logic        redirect, fetch_en;
  logic        misalign_q, misalign_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    redirect  = branch_i | jump_i;
    redir_raw = branch_i ? branch_target_i : jump_target_i;
    redir_tgt = {redir_raw[31:2], 2'b00};
    pc_plus4  = pc_q + 32'd4;
  end

  // Redirect beats stall; a halted fetch holds its PC until redirected.
  always_comb begin
    pc_d = pc_q;
    if (redirect)
      pc_d = redir_tgt;
    else if (state_q == S_RUN && !stall_i)
      pc_d = pc_plus4;
  end

  assign misalign_d = redirect & (|redir_raw[1:0]);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM: next state, keyed off where the PC is heading
  always_comb begin
    state_d = state_q;
    if ({1'b0, pc_d} >= PC_LIMIT)
      state_d = S_HALT;
    else if (redirect)
      state_d = S_RUN;
  end

  // FSM: outputs
  always_comb begin
    halt_o   = (state_q == S_HALT);
    fetch_en = (state_q == S_RUN);
  end

  // IF/ID: squash on flush or redirect (no delay slot), hold on stall.
  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (flush_i || redirect) begin
      ifid_d = '0;
    end else if (stall_i) begin
      ifid_d = ifid_q;
    end else if (fetch_en) begin
      ifid_d.instr = imem_instr_i;
      ifid_d.pc4   = pc_plus4;
      ifid_d.valid = 1'b1;
      cnt_d        = cnt_q + 32'd1;
    end else begin
      ifid_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      ifid_q     <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_pc4_o   = ifid_q.pc4;
  assign ifid_valid_o = ifid_q.valid;
  assign misalign_o   = misalign_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 32-word combinational memory model.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, branch_i, jump_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] imem_addr_o, imem_instr_i;
  logic [31:0] ifid_instr_o, ifid_pc4_o, fetch_cnt_o;
  logic        ifid_valid_o, halt_o, misalign_o;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] mem [32];

  instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o), .ifid_valid_o(ifid_valid_o),
    .halt_o(halt_o), .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    imem_instr_i = 32'h0;
    if (imem_addr_o < 32'd128) imem_instr_i = mem[imem_addr_o[6:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; branch_i = 0; jump_i = 0;
    branch_target_i = 0; jump_target_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    idle();
    rst_i = 0;
    repeat (2) step();
    chk("rst_pc",    imem_addr_o, 32'h0);
    chk("rst_valid", 32'(ifid_valid_o), 0);
    chk("rst_instr", ifid_instr_o, 0);
    chk("rst_pc4",   ifid_pc4_o, 0);
    chk("rst_cnt",   fetch_cnt_o, 0);
    chk("rst_halt",  32'(halt_o), 0);
    chk("rst_mis",   32'(misalign_o), 0);
    rst_i = 1;

    // sequential fetch
    step();
    chk("seq1_pc", imem_addr_o, 32'h4);
    chk("seq1_in", ifid_instr_o, mem[0]);
    chk("seq1_p4", ifid_pc4_o, 32'h4);
    chk("seq1_v",  32'(ifid_valid_o), 1);
    chk("seq1_c",  fetch_cnt_o, 1);
    step();
    chk("seq2_pc", imem_addr_o, 32'h8);
    chk("seq2_in", ifid_instr_o, mem[1]);
    chk("seq2_c",  fetch_cnt_o, 2);

    // stall two cycles at pc=8
    stall_i = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stl_pc", imem_addr_o, 32'h8);
      chk("stl_in", ifid_instr_o, mem[1]);
      chk("stl_c",  fetch_cnt_o, 2);
    end
    stall_i = 0;
    step();
    chk("res_pc", imem_addr_o, 32'hC);
    chk("res_in", ifid_instr_o, mem[2]);
    chk("res_c",  fetch_cnt_o, 3);

    // branch with stall: redirect wins, IF/ID bubbled
    branch_i = 1; branch_target_i = 32'h14; stall_i = 1;
    step();
    chk("br_pc", imem_addr_o, 32'h14);
    chk("br_v",  32'(ifid_valid_o), 0);
    chk("br_in", ifid_instr_o, 0);
    chk("br_p4", ifid_pc4_o, 0);
    chk("br_c",  fetch_cnt_o, 3);
    idle();
    step();
    chk("br2_in", ifid_instr_o, mem[5]);
    chk("br2_p4", ifid_pc4_o, 32'h18);
    chk("br2_c",  fetch_cnt_o, 4);

    // misaligned jump target
    jump_i = 1; jump_target_i = 32'h0E;
    step();
    chk("mis_pc", imem_addr_o, 32'hC);
    chk("mis_p",  32'(misalign_o), 1);
    chk("mis_v",  32'(ifid_valid_o), 0);
    idle();
    step();
    chk("mis_clr", 32'(misalign_o), 0);
    chk("mis_in",  ifid_instr_o, mem[3]);
    chk("mis_c",   fetch_cnt_o, 5);

    // branch and jump together: branch wins
    branch_i = 1; branch_target_i = 32'h40; jump_i = 1; jump_target_i = 32'h20;
    step();
    chk("bj_pc",  imem_addr_o, 32'h40);
    chk("bj_mis", 32'(misalign_o), 0);
    idle();

    // run off the end of memory
    jump_i = 1; jump_target_i = 32'h78;
    step();
    idle();
    chk("end_pc0", imem_addr_o, 32'h78);
    step();
    chk("end_pc1", imem_addr_o, 32'h7C);
    chk("end_h1",  32'(halt_o), 0);
    chk("end_c1",  fetch_cnt_o, 6);
    step();
    chk("hlt_pc", imem_addr_o, 32'h80);
    chk("hlt_h",  32'(halt_o), 1);
    chk("hlt_in", ifid_instr_o, mem[31]);
    chk("hlt_c",  fetch_cnt_o, 7);
    step();
    chk("hlt2_pc", imem_addr_o, 32'h80);
    chk("hlt2_v",  32'(ifid_valid_o), 0);
    chk("hlt2_in", ifid_instr_o, 0);
    chk("hlt2_c",  fetch_cnt_o, 7);
    chk("hlt2_h",  32'(halt_o), 1);

    // out-of-range redirect stays halted
    jump_i = 1; jump_target_i = 32'h100;
    step();
    chk("oor_pc", imem_addr_o, 32'h100);
    chk("oor_h",  32'(halt_o), 1);
    jump_target_i = 32'h04;
    step();
    chk("rec_h",  32'(halt_o), 0);
    chk("rec_pc", imem_addr_o, 32'h4);
    chk("rec_v",  32'(ifid_valid_o), 0);
    idle();
    step();
    chk("rec_in", ifid_instr_o, mem[1]);
    chk("rec_c",  fetch_cnt_o, 8);

    // stall plus flush: PC holds, IF/ID bubbled
    stall_i = 1; flush_i = 1;
    step();
    chk("sf_pc", imem_addr_o, 32'h8);
    chk("sf_v",  32'(ifid_valid_o), 0);
    chk("sf_c",  fetch_cnt_o, 8);
    idle();
    step();
    chk("sf2_in", ifid_instr_o, mem[2]);
    chk("sf2_c",  fetch_cnt_o, 9);

    // asynchronous reset between edges
    #2 rst_i = 0;
    #1;
    chk("ar_pc", imem_addr_o, 32'h0);
    chk("ar_v",  32'(ifid_valid_o), 0);
    chk("ar_c",  fetch_cnt_o, 0);
    chk("ar_h",  32'(halt_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
